// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FSM states, IEEE-754 single constants and the
// unrounded result format handed to the rounding stage.
package fpu_pkg;

    localparam int          BIAS           = 127;
    localparam int          MBITS          = 24;
    localparam logic [7:0]  EXP_MAX        = 8'hFF;
    localparam logic [22:0] CANON_NAN_FRAC = 23'h400000;

    // Flag vector layout is {NV, OF, UF}.
    localparam logic [2:0]  FLAG_NV = 3'b100;
    localparam logic [2:0]  FLAG_OF = 3'b010;
    localparam logic [2:0]  FLAG_UF = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic [2:0]  grs;
    } fp_unrounded_t;

endpackage

// File: rtl/fpu_mul_iter_if.sv
// Operand/result handshake bundle between the FPU issue logic, the iterative
// multiplier and the rounder.
interface fpu_mul_iter_if;
    import fpu_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          out_valid;
    logic          out_ready;
    fp_unrounded_t out;
    logic [2:0]    out_flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, out_flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, out_flags
    );

endinterface

// File: rtl/fpu_mul_classify.sv
// Combinational operand classifier; subnormals are flushed and report as zero.
module fpu_mul_classify (
    input  logic [30:0] i_operand,
    output logic        o_is_zero,
    output logic        o_is_inf,
    output logic        o_is_nan
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exp     = i_operand[30:23];
    assign w_frac    = i_operand[22:0];

    assign o_is_zero = (w_exp == 8'h00);
    assign o_is_inf  = (w_exp == 8'hFF) && (w_frac == 23'd0);
    assign o_is_nan  = (w_exp == 8'hFF) && (w_frac != 23'd0);

endmodule

// File: rtl/fpu_mul_iter.sv
// Iterative single-precision multiplier: shift-add significand product, one
// multiplier bit per clock, producing an unrounded {sign, exp, mant, g, r, s}.
module fpu_mul_iter
    import fpu_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    fpu_mul_iter_if.slave bus
);

    localparam int CNT_W = $clog2(MBITS);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [47:0]         r_prod;
    logic [23:0]         r_mcand;
    logic signed [9:0]   r_exp;
    logic                r_sign;
    fp_unrounded_t       r_out;
    logic [2:0]          r_flags;
    logic                r_out_valid;

    logic                w_a_zero, w_a_inf, w_a_nan;
    logic                w_b_zero, w_b_inf, w_b_nan;
    logic                w_sign;
    logic signed [9:0]   w_exp_sum;
    logic                w_spec;
    fp_unrounded_t       w_spec_out;
    logic [2:0]          w_spec_flags;
    logic [24:0]         w_sum;
    logic [47:0]         w_prod_next;
    logic signed [9:0]   w_exp_norm;
    fp_unrounded_t       w_norm_out;
    logic [2:0]          w_norm_flags;

    fpu_mul_classify u_cls_a (
        .i_operand (bus.a[30:0]),
        .o_is_zero (w_a_zero),
        .o_is_inf  (w_a_inf),
        .o_is_nan  (w_a_nan)
    );

    fpu_mul_classify u_cls_b (
        .i_operand (bus.b[30:0]),
        .o_is_zero (w_b_zero),
        .o_is_inf  (w_b_inf),
        .o_is_nan  (w_b_nan)
    );

    assign w_sign    = bus.a[31] ^ bus.b[31];
    assign w_exp_sum = $signed({2'b00, bus.a[30:23]}) + $signed({2'b00, bus.b[30:23]})
                     - $signed(10'(BIAS));

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_spec       = 1'b1;
        w_spec_out   = '0;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_out.exp  = EXP_MAX;
            w_spec_out.mant = CANON_NAN_FRAC;
            w_spec_flags    = FLAG_NV;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_out.sign = w_sign;
            w_spec_out.exp  = EXP_MAX;
        end else if (w_a_zero || w_b_zero) begin
            w_spec_out.sign = w_sign;
        end else begin
            w_spec = 1'b0;
        end
    end

    // Add the multiplicand into the upper half when the current multiplier
    // bit (r_prod[0]) is set, then shift the whole product right by one.
    assign w_sum       = {1'b0, r_prod[47:24]} + (r_prod[0] ? {1'b0, r_mcand} : 25'd0);
    assign w_prod_next = {w_sum, r_prod[23:1]};

    always_comb begin
        w_norm_out      = '0;
        w_norm_flags    = '0;
        w_norm_out.sign = r_sign;
        if (r_prod[47]) begin
            w_norm_out.mant = r_prod[46:24];
            w_norm_out.grs  = {r_prod[23], r_prod[22], |r_prod[21:0]};
            w_exp_norm      = r_exp + 10'sd1;
        end else begin
            w_norm_out.mant = r_prod[45:23];
            w_norm_out.grs  = {r_prod[22], r_prod[21], |r_prod[20:0]};
            w_exp_norm      = r_exp;
        end
        if (w_exp_norm >= 10'sd255) begin
            w_norm_out.exp  = EXP_MAX;
            w_norm_out.mant = '0;
            w_norm_out.grs  = '0;
            w_norm_flags    = FLAG_OF;
        end else if (w_exp_norm <= 10'sd0) begin
            w_norm_out.exp  = 8'h00;
            w_norm_out.mant = '0;
            w_norm_out.grs  = '0;
            w_norm_flags    = FLAG_UF;
        end else begin
            w_norm_out.exp  = w_exp_norm[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_spec) begin
                            r_out       <= w_spec_out;
                            r_flags     <= w_spec_flags;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_mcand <= {1'b1, bus.a[22:0]};
                            r_prod  <= {24'd0, 1'b1, bus.b[22:0]};
                            r_exp   <= w_exp_sum;
                            r_sign  <= w_sign;
                            r_cnt   <= '0;
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(MBITS - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_out       <= w_norm_out;
                    r_flags     <= w_norm_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_flags = r_flags;

endmodule

// File: tb/tb_fpu_mul_iter.sv
// Directed bench for fpu_mul_iter: vector table plus backpressure and
// mid-operation reset sequences.
module tb_fpu_mul_iter;
    import fpu_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    fpu_mul_iter_if bus ();

    fpu_mul_iter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        @(negedge clock);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    // Latency = number of rising edges after the accepting edge up to and
    // including the first edge at which out_valid is seen high.
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clock);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [34:0] res, output logic [2:0] flg, output int lat);
        accept(a, b);
        wait_valid(lat);
        res = bus.out;
        flg = bus.out_flags;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
    endtask

    vec_t        vecs [19];
    logic [34:0] res, held;
    logic [2:0]  flg, held_flg;
    int          lat, highs;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 35'h202000000, 3'b000, 26};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 35'h1FC000011, 3'b000, 26};
        vecs[2]  = '{32'h7F000000, 32'h7F000000, 35'h3FC000000, 3'b010, 26};
        vecs[3]  = '{32'h00800000, 32'h00800000, 35'h000000000, 3'b001, 26};
        vecs[4]  = '{32'h7FC00000, 32'h3F800000, 35'h3FE000000, 3'b100, 1};
        vecs[5]  = '{32'h7F800000, 32'h80000000, 35'h3FE000000, 3'b100, 1};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 35'h7FC000000, 3'b000, 1};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 35'h400000000, 3'b000, 1};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 35'h000000000, 3'b000, 1};
        vecs[9]  = '{32'hC0400000, 32'h3F000000, 35'h5FE000000, 3'b000, 26};
        vecs[10] = '{32'h3FC00000, 32'h3FC00000, 35'h200800000, 3'b000, 26};
        vecs[11] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 35'h203FFFFF1, 3'b000, 26};
        vecs[12] = '{32'h3F800001, 32'h3FC00000, 35'h1FE00000C, 3'b000, 26};
        vecs[13] = '{32'h7F000000, 32'h3F800000, 35'h3F8000000, 3'b000, 26};
        vecs[14] = '{32'h7F400000, 32'h3FC00000, 35'h3FC000000, 3'b010, 26};
        vecs[15] = '{32'h00800000, 32'h3F800000, 35'h004000000, 3'b000, 26};
        vecs[16] = '{32'h00800000, 32'h3F000000, 35'h000000000, 3'b001, 26};
        vecs[17] = '{32'h00000001, 32'h7F800000, 35'h3FE000000, 3'b100, 1};
        vecs[18] = '{32'h7F800000, 32'hFF800000, 35'h7FC000000, 3'b000, 1};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        #23;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out",       64'(bus.out),       64'd0);
        check("rst_flags",     64'(bus.out_flags), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, res, flg, lat);
            check($sformatf("vec%0d_out", i),   64'(res), 64'(vecs[i].res));
            check($sformatf("vec%0d_flags", i), 64'(flg), 64'(vecs[i].flags));
            check($sformatf("vec%0d_lat", i),   64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure: result and flags must hold and new operands be ignored.
        accept(32'h3FC00000, 32'h40000000);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd26);
        held     = bus.out;
        held_flg = bus.out_flags;
        check("bp_out", 64'(held), 64'h202000000);
        for (int k = 0; k < 5; k++) begin
            bus.a        = 32'h40400000;
            bus.b        = 32'h40400000;
            bus.in_valid = 1'b1;
            @(negedge clock);
            check($sformatf("bp_hold_out%0d", k),   64'(bus.out),       64'(held));
            check($sformatf("bp_hold_flags%0d", k), 64'(bus.out_flags), 64'(held_flg));
            check($sformatf("bp_in_ready%0d", k),   64'(bus.in_ready),  64'd0);
            check($sformatf("bp_valid%0d", k),      64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 64'(bus.in_ready),  64'd1);
        check("bp_release_valid",    64'(bus.out_valid), 64'd0);
        check("bp_release_out",      64'(bus.out),       64'h202000000);

        // Reset during MUL count 10 aborts the operation with no result.
        accept(32'h3FC00000, 32'h40000000);
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid",    64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        highs = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.out_valid) highs++;
        end
        check("mid_rst_no_result", 64'(highs), 64'd0);
        run_op(32'h3FC00000, 32'h40000000, res, flg, lat);
        check("post_rst_out",   64'(res), 64'h202000000);
        check("post_rst_flags", 64'(flg), 64'd0);
        check("post_rst_lat",   64'(lat), 64'd26);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_mul_iter.md
Name: fpu_mul_iter

Overview:
- Iterative single-precision FP multiplier. It produces the 35-bit unrounded result {sign, exp[7:0], mant[22:0], g, r, s} consumed directly by the FPU rounding stage.
- Mantissa product is built by a shift-add loop, one multiplier bit per cycle.
- Valid/ready handshake on both sides.
- Sits in the FPU execute path, directly upstream of the rounder.

Parameters:
- BIAS, 127, exponent bias.
- MBITS, 24, significand width including hidden bit; equals the iteration count.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block idle, accepts operands
- a  in  32  IEEE-754 single operand A
- b  in  32  IEEE-754 single operand B
- out_valid  out  1  result present
- out_ready  in  1  downstream (rounder side) accepts result
- out  out  35  {sign[34], exp[33:26], mant[25:3], g[2], r[1], s[0]}
- out_flags  out  3  {NV, OF, UF}

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). Reset forces state IDLE, out_valid=0, out=0, out_flags=0; in_ready=1 after release.
- States and transitions:
  - IDLE: in_ready=1. Handshake (in_valid&&in_ready) latches a and b. Go to DONE if the special case applies, else MUL.
  - MUL: 24 cycles. Counter 0..23 walks multiplier bits LSB first, accumulating the 48-bit product P (shift-add). Count 23 -> NORM.
  - NORM: 1 cycle. Normalise, detect exponent range, load out -> DONE.
  - DONE: out_valid=1; out and out_flags held stable. out_ready -> IDLE. No new operand is accepted in the same cycle.
- in_ready = (state==IDLE) only. The block is not pipelined: one operation in flight.
- Latency:
  - Normal operands: out_valid rises 26 clocks after the accepting edge.
  - Special operands: 1 clock after.
- Special cases, decided at accept. All produce g=r=s=0.
  - Subnormal inputs are flushed to zero (exp==0 treated as ±0).
  - NaN operand, or inf*0: out = {0, 0xFF, 0x400000, 000}, NV=1.
  - inf*finite-nonzero or inf*inf: {sa^sb, 0xFF, 0, 000}.
  - zero*finite: {sa^sb, 0x00, 0, 000}.
- Normal path arithmetic:
  - Sign = sa^sb.
  - E = ea+eb-BIAS, computed as a 10-bit signed value.
  - Significands are {1, frac}, 24 bits each.
- NORM:
  - If P[47]: mant=P[46:24], g=P[23], r=P[22], s=|P[21:0], E=E+1.
  - Else: mant=P[45:23], g=P[22], r=P[21], s=|P[20:0].
  - E>=255: out={sign, 0xFF, 0, 000}, OF=1. The rounder leaves exp==0xFF untouched.
  - E<=0: out={sign, 0x00, 0, 000}, UF=1 (flush-to-zero).
  - Else exp=E[7:0].
- Backpressure: while out_valid && !out_ready, out and out_flags do not change.
- Reset mid-operation aborts the operation; no result is emitted.
- out and out_flags are don't-care while out_valid=0, but hold their last value (registered).

Decomposition:
- fpu_pkg holds:
  - state enum (IDLE, MUL, NORM, DONE)
  - constants BIAS, EXP_MAX=8'hFF, CANON_NAN_FRAC=23'h400000
  - typedef fp_unrounded_t, the packed 35-bit struct {sign, exp, mant, grs}, shared with the rounder
- One natural sub-module: fpu_mul_classify. It is combinational: operand -> {is_zero, is_inf, is_nan} with subnormal flush.

Test Plan:
- a=0x3FC00000, b=0x40000000 (1.5*2.0) -> out=35'h202000000, flags=000, out_valid exactly 26 clocks after accept.
- a=b=0x3F800001 -> P=0x400001000001, out={0, 0x7F, 23'h000002, g=0, r=0, s=1}, flags=000.
- a=b=0x7F000000 -> out={0, 0xFF, 0, 000}, OF=1. a=b=0x00800000 -> out={0, 0x00, 0, 000}, UF=1.
- a=0x7FC00000, b=0x3F800000 and a=0x7F800000, b=0x80000000 -> both give out={0, 0xFF, 0x400000, 000}, NV=1, out_valid 1 clock after accept.
- Normal op with out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, in_valid ignored. Then out_ready=1 -> next cycle IDLE, in_ready=1.
- reset_n low during MUL count 10 -> immediately state IDLE, out_valid=0. After release, a new op (1.5*2.0) completes with the correct result and latency.
